// File: rtl/fpu_ret_collect.sv
// Completion collector for the three-port FP SIMD unit: in-order FIFO of u1/u3/u5 words,
// valid/ready drain to retire, sticky exception flags. Optional same-cycle bypass: FPRET_BYPASS_EN.
module fpu_ret_collect #(
  parameter int DEPTH = 8,
  parameter int RETW  = 14
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [RETW-1:0] u1_ret,
  input  logic            u1_ret_en,
  input  logic [RETW-1:0] u3_ret,
  input  logic            u3_ret_en,
  input  logic [RETW-1:0] u5_ret,
  input  logic            u5_ret_en,
  output logic [RETW-1:0] out_ret,
  output logic [1:0]      out_port,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            almost_full,
  output logic [5:0]      flags_sticky,
  input  logic            flags_clr,
  output logic            ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int NP = 3;

  logic [RETW-1:0] mem_ret  [DEPTH];
  logic [1:0]      mem_port [DEPTH];

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [CW-1:0]   count_nxt;
  logic [CW-1:0]   free;

  logic [RETW-1:0] ret_in  [NP];
  logic [NP-1:0]   en_in;
  logic [NP-1:0]   wr_en;
  logic [AW-1:0]   wr_addr [NP];
  logic [1:0]      n_wr;
  logic [1:0]      first_idx;
  logic            any_en;
  logic            fifo_empty;
  logic            bypass_sel;
  logic            bypass_take;
  logic            deq;
  logic            retire;
  logic            drop;
  logic [5:0]      retire_flags;

  always_comb begin
    ret_in[0] = u1_ret;
    ret_in[1] = u3_ret;
    ret_in[2] = u5_ret;
    en_in     = {u5_ret_en, u3_ret_en, u1_ret_en};
  end

  // Lowest-numbered enabled port is the one eligible for the bypass path.
  always_comb begin
    any_en    = |en_in;
    first_idx = 2'd0;
    for (int i = NP - 1; i >= 0; i--) begin
      if (en_in[i]) first_idx = 2'(i);
    end
  end

  // Head presentation: stored entries always win over the bypass word.
  always_comb begin
    fifo_empty = (count == '0);
    bypass_sel = 1'b0;
`ifdef FPRET_BYPASS_EN
    bypass_sel = fifo_empty && any_en;
`endif
    out_valid = 1'b0;
    out_ret   = '0;
    out_port  = 2'd0;
    if (!fifo_empty) begin
      out_valid = 1'b1;
      out_ret   = mem_ret[rd_ptr];
      out_port  = mem_port[rd_ptr];
    end else if (bypass_sel) begin
      out_valid = 1'b1;
      out_ret   = ret_in[first_idx];
      out_port  = first_idx;
    end
    deq          = !fifo_empty && out_ready;
    retire       = out_valid && out_ready;
    bypass_take  = bypass_sel && out_ready;
    retire_flags = retire ? out_ret[5:0] : 6'd0;
  end

  // Slot allocation in u1,u3,u5 order; a same-cycle dequeue does not free a slot.
  // NOTE: n_wr is a running total inside one combinational pass, so it uses blocking
  // assignments and is given a default before the loop so no latch is inferred.
  always_comb begin
    free = CW'(DEPTH) - count;
    n_wr = 2'd0;
    drop = 1'b0;
    for (int i = 0; i < NP; i++) begin
      wr_en[i]   = 1'b0;
      wr_addr[i] = wr_ptr + AW'(n_wr);
      if (en_in[i] && !(bypass_take && (first_idx == 2'(i)))) begin
        if (CW'(n_wr) < free) begin
          wr_en[i] = 1'b1;
          n_wr     = n_wr + 2'd1;
        end else begin
          drop = 1'b1;
        end
      end
    end
    count_nxt = count + CW'(n_wr) - CW'(deq);
  end

  // NOTE: storage carries no reset; out_* are gated by count, so stale contents are
  // never visible and the array can map onto plain flops or a register file.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (wr_en[i]) begin
        mem_ret[wr_addr[i]]  <= ret_in[i];
        mem_port[wr_addr[i]] <= 2'(i);
      end
    end
  end

  // NOTE: all state updates are non-blocking so every register sees pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      almost_full  <= 1'b0;
      flags_sticky <= 6'd0;
      ovf          <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr + AW'(n_wr);
      count       <= count_nxt;
      almost_full <= (count_nxt > CW'(DEPTH - 3));
      if (deq) rd_ptr <= rd_ptr + AW'(1);

      // A clear coinciding with a retire keeps only the retiring word's flags.
      if (flags_clr) flags_sticky <= retire_flags;
      else           flags_sticky <= flags_sticky | retire_flags;

      if (drop)           ovf <= 1'b1;
      else if (flags_clr) ovf <= 1'b0;
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));

`ifndef FPRET_BYPASS_EN
  a_head_stable: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_ret) && $stable(out_port)));
`endif

endmodule

// File: tb/tb_fpu_ret_collect.sv
// Directed bench for fpu_ret_collect (default build): vector table plus wrap,
// flag-clear and asynchronous-reset sequences.
module tb_fpu_ret_collect;

  logic        clk = 1'b0;
  logic        rst;
  logic [13:0] u1_ret, u3_ret, u5_ret;
  logic        u1_ret_en, u3_ret_en, u5_ret_en;
  logic [13:0] out_ret;
  logic [1:0]  out_port;
  logic        out_valid;
  logic        out_ready;
  logic        almost_full;
  logic [5:0]  flags_sticky;
  logic        flags_clr;
  logic        ovf;

  int n_tests = 0;
  int n_fail  = 0;

  fpu_ret_collect dut (
    .clk(clk), .rst(rst),
    .u1_ret(u1_ret), .u1_ret_en(u1_ret_en),
    .u3_ret(u3_ret), .u3_ret_en(u3_ret_en),
    .u5_ret(u5_ret), .u5_ret_en(u5_ret_en),
    .out_ret(out_ret), .out_port(out_port), .out_valid(out_valid),
    .out_ready(out_ready), .almost_full(almost_full),
    .flags_sticky(flags_sticky), .flags_clr(flags_clr), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] u1;  logic u1e;
    logic [13:0] u3;  logic u3e;
    logic [13:0] u5;  logic u5e;
    logic        rdy; logic clr;
    logic        ev;  logic [13:0] eret; logic [1:0] eport;
    logic        eaf; logic [5:0]  eflags; logic ovfe;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [13:0] u1, logic u1e, logic [13:0] u3, logic u3e,
                              logic [13:0] u5, logic u5e, logic rdy, logic clr,
                              logic ev, logic [13:0] eret, logic [1:0] eport,
                              logic eaf, logic [5:0] eflags, logic ovfe);
    vec_t v;
    v.u1 = u1; v.u1e = u1e; v.u3 = u3; v.u3e = u3e; v.u5 = u5; v.u5e = u5e;
    v.rdy = rdy; v.clr = clr; v.ev = ev; v.eret = eret; v.eport = eport;
    v.eaf = eaf; v.eflags = eflags; v.ovfe = ovfe;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    u1_ret = '0; u3_ret = '0; u5_ret = '0;
    u1_ret_en = 1'b0; u3_ret_en = 1'b0; u5_ret_en = 1'b0;
    out_ready = 1'b0; flags_clr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    int recv;
    rst = 1'b1;
    drive_idle();
    tick();
    tick();
    rst = 1'b0;

    check("reset out_valid", 32'(out_valid), 0);
    check("reset out_ret", 32'(out_ret), 0);
    check("reset out_port", 32'(out_port), 0);
    check("reset almost_full", 32'(almost_full), 0);
    check("reset flags", 32'(flags_sticky), 0);
    check("reset ovf", 32'(ovf), 0);

    //                 u1       e  u3       e  u5       e  rdy clr  v  ret      port af flags  ovf
    // single word, then retire
    vecs.push_back(mk(14'h0011, 1, 14'h0000, 0, 14'h0000, 0, 1, 0,  1, 14'h0011, 0, 0, 6'h00, 0));
    vecs.push_back(mk(14'h0000, 0, 14'h0000, 0, 14'h0000, 0, 1, 0,  0, 14'h0000, 0, 0, 6'h11, 0));
    vecs.push_back(mk(14'h0000, 0, 14'h0000, 0, 14'h0000, 0, 0, 1,  0, 14'h0000, 0, 0, 6'h00, 0));
    // three ports in one cycle, hold, then drain in port order
    vecs.push_back(mk(14'h0040, 1, 14'h0081, 1, 14'h00C2, 1, 0, 0,  1, 14'h0040, 0, 0, 6'h00, 0));
    vecs.push_back(mk(14'h0000, 0, 14'h0000, 0, 14'h0000, 0, 0, 0,  1, 14'h0040, 0, 0, 6'h00, 0));
    vecs.push_back(mk(14'h0000, 0, 14'h0000, 0, 14'h0000, 0, 1, 0,  1, 14'h0081, 1, 0, 6'h00, 0));
    vecs.push_back(mk(14'h0000, 0, 14'h0000, 0, 14'h0000, 0, 1, 0,  1, 14'h00C2, 2, 0, 6'h01, 0));
    vecs.push_back(mk(14'h0000, 0, 14'h0000, 0, 14'h0000, 0, 1, 0,  0, 14'h0000, 0, 0, 6'h03, 0));
    // fill to overflow: third cycle stores u1,u3 and drops u5
    vecs.push_back(mk(14'h0100, 1, 14'h0101, 1, 14'h0102, 1, 0, 0,  1, 14'h0100, 0, 0, 6'h03, 0));
    vecs.push_back(mk(14'h0103, 1, 14'h0104, 1, 14'h0105, 1, 0, 0,  1, 14'h0100, 0, 1, 6'h03, 0));
    vecs.push_back(mk(14'h0106, 1, 14'h0107, 1, 14'h0108, 1, 0, 0,  1, 14'h0100, 0, 1, 6'h03, 1));
    vecs.push_back(mk(14'h0000, 0, 14'h0000, 0, 14'h0000, 0, 1, 0,  1, 14'h0101, 1, 1, 6'h03, 1));
    vecs.push_back(mk(14'h0000, 0, 14'h0000, 0, 14'h0000, 0, 1, 0,  1, 14'h0102, 2, 1, 6'h03, 1));
    vecs.push_back(mk(14'h0000, 0, 14'h0000, 0, 14'h0000, 0, 1, 0,  1, 14'h0103, 0, 0, 6'h03, 1));
    vecs.push_back(mk(14'h0000, 0, 14'h0000, 0, 14'h0000, 0, 1, 0,  1, 14'h0104, 1, 0, 6'h03, 1));
    vecs.push_back(mk(14'h0000, 0, 14'h0000, 0, 14'h0000, 0, 1, 0,  1, 14'h0105, 2, 0, 6'h07, 1));
    vecs.push_back(mk(14'h0000, 0, 14'h0000, 0, 14'h0000, 0, 1, 0,  1, 14'h0106, 0, 0, 6'h07, 1));
    vecs.push_back(mk(14'h0000, 0, 14'h0000, 0, 14'h0000, 0, 1, 0,  1, 14'h0107, 1, 0, 6'h07, 1));
    vecs.push_back(mk(14'h0000, 0, 14'h0000, 0, 14'h0000, 0, 1, 0,  0, 14'h0000, 0, 0, 6'h07, 1));
    vecs.push_back(mk(14'h0000, 0, 14'h0000, 0, 14'h0000, 0, 0, 1,  0, 14'h0000, 0, 0, 6'h00, 0));
    // ready while empty is ignored
    vecs.push_back(mk(14'h0000, 0, 14'h0000, 0, 14'h0000, 0, 1, 0,  0, 14'h0000, 0, 0, 6'h00, 0));
    // single-port writes, including same-cycle enqueue + dequeue
    vecs.push_back(mk(14'h0000, 0, 14'h0009, 1, 14'h0000, 0, 1, 0,  1, 14'h0009, 1, 0, 6'h00, 0));
    vecs.push_back(mk(14'h0000, 0, 14'h0000, 0, 14'h000A, 1, 1, 0,  1, 14'h000A, 2, 0, 6'h09, 0));
    vecs.push_back(mk(14'h0000, 0, 14'h0000, 0, 14'h0000, 0, 0, 0,  1, 14'h000A, 2, 0, 6'h09, 0));
    vecs.push_back(mk(14'h0000, 0, 14'h0000, 0, 14'h0000, 0, 1, 0,  0, 14'h0000, 0, 0, 6'h0B, 0));
    // u1 + u5 occupy two consecutive entries
    vecs.push_back(mk(14'h0010, 1, 14'h0000, 0, 14'h0020, 1, 0, 0,  1, 14'h0010, 0, 0, 6'h0B, 0));
    vecs.push_back(mk(14'h0000, 0, 14'h0000, 0, 14'h0000, 0, 1, 0,  1, 14'h0020, 2, 0, 6'h1B, 0));
    vecs.push_back(mk(14'h0000, 0, 14'h0000, 0, 14'h0000, 0, 1, 0,  0, 14'h0000, 0, 0, 6'h3B, 0));
    // clear coinciding with a retire of flags 04
    vecs.push_back(mk(14'h0204, 1, 14'h0000, 0, 14'h0000, 0, 0, 0,  1, 14'h0204, 0, 0, 6'h3B, 0));
    vecs.push_back(mk(14'h0000, 0, 14'h0000, 0, 14'h0000, 0, 1, 1,  0, 14'h0000, 0, 0, 6'h04, 0));

    foreach (vecs[i]) begin
      u1_ret = vecs[i].u1; u1_ret_en = vecs[i].u1e;
      u3_ret = vecs[i].u3; u3_ret_en = vecs[i].u3e;
      u5_ret = vecs[i].u5; u5_ret_en = vecs[i].u5e;
      out_ready = vecs[i].rdy; flags_clr = vecs[i].clr;
      tick();
      check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].ev));
      check($sformatf("row%0d out_ret", i), 32'(out_ret), 32'(vecs[i].eret));
      check($sformatf("row%0d out_port", i), 32'(out_port), 32'(vecs[i].eport));
      check($sformatf("row%0d almost_full", i), 32'(almost_full), 32'(vecs[i].eaf));
      check($sformatf("row%0d flags", i), 32'(flags_sticky), 32'(vecs[i].eflags));
      check($sformatf("row%0d ovf", i), 32'(ovf), 32'(vecs[i].ovfe));
    end
    drive_idle();

    // Pointer wrap: 20 words through u1 with out_ready toggling, order must hold.
    sent = 0;
    recv = 0;
    for (int c = 0; c < 200 && recv < 20; c++) begin
      out_ready = ((c % 4) < 2);
      if (out_ready && out_valid) begin
        check($sformatf("wrap word%0d", recv), 32'(out_ret), 32'(recv));
        recv++;
      end
      if ((c % 2) == 0 && sent < 20) begin
        u1_ret    = 14'(sent);
        u1_ret_en = 1'b1;
        sent++;
      end else begin
        u1_ret_en = 1'b0;
      end
      tick();
    end
    drive_idle();
    check("wrap words received", 32'(recv), 20);
    check("wrap ovf", 32'(ovf), 0);
    tick();
    check("wrap drained", 32'(out_valid), 0);

    // Asynchronous reset mid-drain with five entries held.
    u1_ret = 14'h0031; u3_ret = 14'h0032; u5_ret = 14'h0033;
    u1_ret_en = 1'b1; u3_ret_en = 1'b1; u5_ret_en = 1'b1;
    tick();
    tick();
    check("pre-reset almost_full", 32'(almost_full), 1);
    drive_idle();
    out_ready = 1'b1;
    tick();
    check("pre-reset out_valid", 32'(out_valid), 1);
    check("pre-reset out_ret", 32'(out_ret), 32'h0032);
    check("pre-reset almost_full low", 32'(almost_full), 0);
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("async reset out_valid", 32'(out_valid), 0);
    check("async reset out_ret", 32'(out_ret), 0);
    check("async reset flags", 32'(flags_sticky), 0);
    #2;
    rst = 1'b0;
    tick();
    check("post-reset out_valid", 32'(out_valid), 0);
    check("post-reset almost_full", 32'(almost_full), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
